reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; next generation of the CPU's 16x8 two-read/one-write register file.
- Adds:
  - configurable width, depth and read-port count;
  - registered reads with write-to-read bypass;
  - stall hold on cpu_paused;
  - a self-timed clear sequencer;
  - a debug access port, usable only while the CPU is paused.
- Sits between decode (read addresses) and writeback (write port); the debug port connects to the debug/monitor unit.

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_paused  in  1  CPU stall; holds read outputs, blocks CPU writes, enables debug port
- we  in  1  CPU write enable
- wa  in  ADDR_W  CPU write address
- wd  in  DATA_W  CPU write data
- ra  in  NUM_RD*ADDR_W  packed read addresses; port k = ra[k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- clr_start  in  1  pulse: start clearing all registers
- busy  out  1  clear sequence in progress
- dbg_req  in  1  debug access request, level, held until ack
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle acknowledge
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack

Behaviour:
- Reset:
  - rst_n low asynchronously zeroes all DEPTH registers, rd_data, dbg_rdata, dbg_ack, busy and the clear counter.
  - FSM goes to IDLE.
- FSM states: IDLE, CLEAR, DBG_ACK.
- CPU write:
  - Committed at the rising edge when we=1, cpu_paused=0 and state=IDLE.
  - Otherwise dropped silently; no queueing.
- Reads:
  - Each edge with cpu_paused=0: rd_data[k] <= mem[ra[k]]. Latency is 1 cycle.
  - Bypass: if a CPU write commits at the same edge and wa==ra[k], rd_data[k] gets wd (new value, not old).
  - cpu_paused=1: rd_data holds its value.
- Clear:
  - clr_start sampled in IDLE → CLEAR, busy=1 from the next cycle.
  - Counter walks registers 0..DEPTH-1, zeroing one per cycle.
  - After the DEPTH-1 write, returns to IDLE; busy=0 the following cycle. busy is high for exactly DEPTH cycles.
  - During CLEAR: CPU writes, debug requests and new clr_start are ignored; rd_data updates normally from memory, so cleared entries read as 0.
  - Reset mid-clear aborts the sequence; all registers are zeroed by the reset anyway.
- Debug:
  - In IDLE with cpu_paused=1 and dbg_req=1 → DBG_ACK at the next edge.
  - At that same edge: if dbg_we, mem[dbg_addr] <= dbg_wdata; dbg_rdata <= pre-write contents of mem[dbg_addr].
  - dbg_ack=1 for exactly one cycle in DBG_ACK, then IDLE.
  - Requester must deassert dbg_req the cycle after ack; a still-high req starts a new access.
  - dbg_req with cpu_paused=0 is ignored; no ack.
  - cpu_paused falling while in DBG_ACK: the ack still completes.
- Priority in IDLE: clr_start > dbg_req > CPU write. In practice CPU write and debug are mutually exclusive via cpu_paused.
- Address arithmetic is modulo DEPTH; the clear counter is ADDR_W+1 bits to detect terminal count without wrap aliasing.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to zero;
  - CPU and debug writes to address 0 are discarded;
  - reads and bypass for address 0 always return 0; bypass never forwards wd for wa=0;
  - debug read of address 0 returns 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package reg_file_pkg:
  - FSM state enum (IDLE, CLEAR, DBG_ACK);
  - default width constants;
  - helper function computing DEPTH from ADDR_W.
- Sub-module reg_file_rd_port:
  - one registered read port with bypass compare and pause hold;
  - instantiated NUM_RD times by generate.
- Storage, FSM, clear counter and debug logic live in the top module.

Test Plan:
- Reset, then write reg i = i*8'h11 for i=0..15; read ra0=i, ra1=15-i; one cycle later rd_data = {expected[15-i], expected[i]} for every i.
- Same-cycle bypass: we=1, wa=3, wd=8'hAA, ra0=3 → next cycle rd_data port0 = AA, not the old 33. Repeat with ZERO_REG_EN and wa=0 → reads 00.
- Pause: cpu_paused=1, change ra, we=1 wa=5 wd=8'h77 → rd_data unchanged, reg5 still 55 after unpause.
- Debug: paused, dbg_req dbg_we=1 addr=7 wdata=8'hC3 → dbg_ack high 1 cycle, dbg_rdata=77; second read of addr 7 → dbg_rdata=C3. dbg_req while unpaused → no ack within 5 cycles.
- Clear: clr_start pulse → busy high exactly 16 cycles; CPU write of wa=2 wd=8'h5A during busy ignored; afterwards all reads return 00.
- Async reset: assert rst_n low mid-clear and mid-debug-ack (between edges) → outputs zero immediately, FSM IDLE, all registers 00.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional build macro: REG_FILE_ZERO_REG_EN (register 0 hardwired to zero).
package reg_file_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    DBG_ACK = 2'd2
  } state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: takes the same-edge write value on an address hit,
// otherwise the stored value; holds while the CPU is paused.
module reg_file_rd_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    // NOTE: default first so every path assigns rd_data_d and no latch is inferred.
    rd_data_d = rd_data_q;
    if (!hold) begin
      if (byp_en && (byp_addr == ra)) rd_data_d = byp_data;
      else                            rd_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks keep all flops updating in parallel.
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD registered read ports, one CPU write port,
// self-timed clear sequencer and a paused-only debug port. Macro: REG_FILE_ZERO_REG_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_paused,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_start,
  output logic                     busy,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     dbg_ack,
  output logic [DATA_W-1:0]        dbg_rdata
);

  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d, clr_cnt_nxt;
  logic              busy_q, busy_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              mem_we, cpu_wr;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic wr_allowed(input logic [ADDR_W-1:0] addr);
`ifdef REG_FILE_ZERO_REG_EN
    return addr != '0;
`else
    return addr == addr;
`endif
  endfunction

  // All writers share one memory port; the FSM state makes them mutually exclusive.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_cnt_nxt = clr_cnt_q + 1'b1;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    mem_we      = 1'b0;
    mem_wa      = wa;
    mem_wdata   = wd;
    cpu_wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (cpu_paused && dbg_req) begin
          state_d     = DBG_ACK;
          dbg_ack_d   = 1'b1;
          dbg_rdata_d = mem_q[dbg_addr];
          mem_we      = dbg_we && wr_allowed(dbg_addr);
          mem_wa      = dbg_addr;
          mem_wdata   = dbg_wdata;
        end else if (we && !cpu_paused && wr_allowed(wa)) begin
          cpu_wr = 1'b1;
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = clr_cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
        if (clr_cnt_nxt == CLR_END) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_nxt;
        end
      end
      DBG_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[mem_wa] = mem_wdata;
`ifdef REG_FILE_ZERO_REG_EN
    mem_d[0] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      // NOTE: storage is reset here on purpose; the clear-on-reset behaviour is architectural.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= busy_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_q       <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (cpu_paused),
      .ra        (ra_k),
      .mem_rdata (mem_q[ra_k]),
      .byp_en    (cpu_wr),
      .byp_addr  (wa),
      .byp_data  (wd),
      .rd_data   (rd_data[k*DATA_W +: DATA_W])
    );
  end

  assign busy      = busy_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, hand-written
// clear/debug/reset sequences and a randomised run against a behavioural model.
module tb_reg_file_mp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 16;

  logic                     clk, rst_n, cpu_paused, we, clr_start, busy;
  logic [ADDR_W-1:0]        wa, dbg_addr;
  logic [DATA_W-1:0]        wd, dbg_wdata, dbg_rdata;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     dbg_req, dbg_we, dbg_ack;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_paused(cpu_paused), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd_data(rd_data), .clr_start(clr_start), .busy(busy),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: storage array, expected read registers, clear progress index.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd  [NUM_RD];
  int                m_clr;
  bit                m_ack;
  logic [DATA_W-1:0] m_dbg_rdata;

  function automatic bit wr_ok(input logic [ADDR_W-1:0] a);
`ifdef REG_FILE_ZERO_REG_EN
    return a != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < NUM_RD; k++) m_rd[k] = '0;
    m_clr       = -1;
    m_ack       = 1'b0;
    m_dbg_rdata = '0;
  endtask

  task automatic model_edge();
    bit idle, commit;
    logic [ADDR_W-1:0] rk;
    idle   = (m_clr < 0) && !m_ack;
    commit = idle && we && !cpu_paused && !clr_start && wr_ok(wa);
    if (!cpu_paused)
      for (int k = 0; k < NUM_RD; k++) begin
        rk = ra[k*ADDR_W +: ADDR_W];
        m_rd[k] = (commit && wa == rk) ? wd : m_mem[rk];
      end
    if (m_clr >= 0) begin
      m_mem[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_clr = -1;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (clr_start) begin
      m_clr = 0;
    end else if (cpu_paused && dbg_req) begin
      m_dbg_rdata = m_mem[dbg_addr];
      if (dbg_we && wr_ok(dbg_addr)) m_mem[dbg_addr] = dbg_wdata;
      m_ack = 1'b1;
    end else if (commit) begin
      m_mem[wa] = wd;
    end
  endtask

  task automatic compare_all();
    logic [NUM_RD*DATA_W-1:0] exp_rd;
    for (int k = 0; k < NUM_RD; k++) exp_rd[k*DATA_W +: DATA_W] = m_rd[k];
    check("model_rd_data", rd_data, exp_rd);
    check("model_busy", busy, m_clr >= 0);
    check("model_dbg_ack", dbg_ack, m_ack);
    check("model_dbg_rdata", dbg_rdata, m_dbg_rdata);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_idle_inputs();
    cpu_paused = 0; we = 0; wa = '0; wd = '0; ra = '0; clr_start = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_rd_data", rd_data, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_dbg_ack", dbg_ack, 1'b0);
    check("arst_dbg_rdata", dbg_rdata, '0);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra0, ra1;
    logic              paused;
    logic [DATA_W-1:0] e0, e1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy_cnt, ack_seen;

    // Stimulus table applied after registers hold i*8'h11.
    vecs[0] = '{we:1, wa:3, wd:8'hAA, ra0:3, ra1:4, paused:0, e0:8'hAA, e1:8'h44};
    vecs[1] = '{we:0, wa:0, wd:8'h00, ra0:3, ra1:0, paused:0, e0:8'hAA, e1:8'h00};
    vecs[2] = '{we:1, wa:5, wd:8'h77, ra0:5, ra1:6, paused:1, e0:8'hAA, e1:8'h00};
    vecs[3] = '{we:1, wa:5, wd:8'h77, ra0:1, ra1:2, paused:1, e0:8'hAA, e1:8'h00};
    vecs[4] = '{we:0, wa:0, wd:8'h00, ra0:5, ra1:3, paused:0, e0:8'h55, e1:8'hAA};
`ifdef REG_FILE_ZERO_REG_EN
    vecs[5] = '{we:1, wa:0, wd:8'hEE, ra0:0, ra1:5, paused:0, e0:8'h00, e1:8'h55};
`else
    vecs[5] = '{we:1, wa:0, wd:8'hEE, ra0:0, ra1:5, paused:0, e0:8'hEE, e1:8'h55};
`endif

    set_idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check("reset_rd_data", rd_data, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_dbg_ack", dbg_ack, 1'b0);
    #19 rst_n = 1'b1;

    // Fill reg i = i*8'h11, then read i / 15-i.
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wa = ADDR_W'(i); wd = DATA_W'(i * 8'h11);
      tick();
    end
    we = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ra = {ADDR_W'(15 - i), ADDR_W'(i)};
      tick();
`ifdef REG_FILE_ZERO_REG_EN
      check("fill_rd", rd_data, {(i == 15) ? 8'h00 : DATA_W'((15 - i) * 8'h11),
                                 (i == 0)  ? 8'h00 : DATA_W'(i * 8'h11)});
`else
      check("fill_rd", rd_data, {DATA_W'((15 - i) * 8'h11), DATA_W'(i * 8'h11)});
`endif
    end

    for (int v = 0; v < 6; v++) begin
      we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
      ra = {vecs[v].ra1, vecs[v].ra0}; cpu_paused = vecs[v].paused;
      tick();
      check($sformatf("vec%0d_rd", v), rd_data, {vecs[v].e1, vecs[v].e0});
    end
    set_idle_inputs();

    // Debug write then read of address 7 while paused.
    cpu_paused = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 7; dbg_wdata = 8'hC3;
    tick();
    check("dbg_wr_ack", dbg_ack, 1'b1);
    check("dbg_wr_rdata", dbg_rdata, 8'h77);
    dbg_req = 0; dbg_we = 0;
    tick();
    check("dbg_ack_one_cycle", dbg_ack, 1'b0);
    dbg_req = 1;
    tick();
    check("dbg_rd_ack", dbg_ack, 1'b1);
    check("dbg_rd_rdata", dbg_rdata, 8'hC3);
    dbg_req = 0;
    tick();

    // Debug request while running is ignored.
    cpu_paused = 0; dbg_req = 1; dbg_we = 1; dbg_wdata = 8'h11;
    ack_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dbg_ack) ack_seen++;
    end
    check("dbg_unpaused_no_ack", ack_seen, 0);
    set_idle_inputs();

    // Clear: busy exactly DEPTH cycles, CPU write during busy dropped.
    clr_start = 1;
    tick();
    clr_start = 0; we = 1; wa = 2; wd = 8'h5A;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      else break;
      tick();
    end
    check("clr_busy_cycles", busy_cnt, DEPTH);
    we = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ra = {ADDR_W'(i), ADDR_W'(i)};
      tick();
      check("clr_rd_zero", rd_data, '0);
    end

    // Async reset in the middle of a clear.
    we = 1; wa = 15; wd = 8'h9C;
    tick();
    we = 0; ra = {ADDR_W'(1), ADDR_W'(15)};
    tick();
    clr_start = 1;
    tick();
    clr_start = 0;
    tick(); tick(); tick();
    check("mid_clr_busy", busy, 1'b1);
    async_reset();
    tick();
    check("post_clr_rst_rd", rd_data, '0);

    // Async reset while dbg_ack is high.
    we = 1; wa = 9; wd = 8'h3C;
    tick();
    we = 0; cpu_paused = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 9;
    tick();
    check("mid_dbg_ack", dbg_ack, 1'b1);
    check("mid_dbg_rdata", dbg_rdata, 8'h3C);
    async_reset();
    set_idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      ra = {ADDR_W'(15 - i), ADDR_W'(i)};
      tick();
      check("post_dbg_rst_rd", rd_data, '0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      cpu_paused = ($urandom_range(0, 3) == 0);
      we         = $urandom_range(0, 1);
      wa         = ADDR_W'($urandom);
      wd         = DATA_W'($urandom);
      ra         = NUM_RD*ADDR_W'($urandom);
      clr_start  = ($urandom_range(0, 59) == 0);
      dbg_req    = ($urandom_range(0, 2) == 0);
      dbg_we     = $urandom_range(0, 1);
      dbg_addr   = ADDR_W'($urandom);
      dbg_wdata  = DATA_W'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
